// File: rtl/pipe_pkg.sv
// Shared constants and width helpers for the pipeline scoreboard.
package pipe_pkg;

    // fwd_sel code meaning "read the operand from the register file"
    localparam int FWD_REGFILE = 32'sd0;

    // Bits needed to name one of nregs architectural registers.
    function automatic int rw_f(input int nregs);
        return $clog2(nregs);
    endfunction

    // Bits needed to hold an age or latency in 0..depth.
    function automatic int lw_f(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks the youngest in-flight producer of a register.
module sb_entry
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int KILL  = 1,
    parameter int LW    = lw_f(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [LW-1:0] i_lat,
    input  logic          i_adv,
    input  logic          i_flush,
    output logic          o_valid,
    output logic [LW-1:0] o_age,
    output logic [LW-1:0] o_lat
);

    localparam logic [LW-1:0] AGE_ONE  = LW'(1);
    localparam logic [LW-1:0] AGE_LAST = LW'(DEPTH);
    localparam logic [LW-1:0] AGE_KILL = LW'(KILL);

    logic          r_valid;
    logic [LW-1:0] r_age;
    logic [LW-1:0] r_lat;
    logic          w_valid_nxt;
    logic [LW-1:0] w_age_nxt;
    logic [LW-1:0] w_lat_nxt;

    // Next-state: flush kills young entries, a new producer replaces the old one,
    // otherwise the entry ages and drops out after writeback.
    always_comb begin
        w_valid_nxt = r_valid;
        w_age_nxt   = r_age;
        w_lat_nxt   = r_lat;
        if (i_flush) begin
            if (r_valid && ((r_age <= AGE_KILL) || (r_age == AGE_LAST))) begin
                w_valid_nxt = 1'b0;
                w_age_nxt   = {LW{1'b0}};
            end else if (r_valid) begin
                w_age_nxt = r_age + AGE_ONE;
            end else begin
                w_valid_nxt = 1'b0;
            end
        end else if (i_load) begin
            w_valid_nxt = 1'b1;
            w_age_nxt   = AGE_ONE;
            w_lat_nxt   = i_lat;
        end else if (i_adv && r_valid) begin
            if (r_age == AGE_LAST) begin
                w_valid_nxt = 1'b0;
                w_age_nxt   = {LW{1'b0}};
            end else begin
                w_age_nxt = r_age + AGE_ONE;
            end
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // Entry state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_age   <= {LW{1'b0}};
            r_lat   <= {LW{1'b0}};
        end else begin
            r_valid <= w_valid_nxt;
            r_age   <= w_age_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_age   = r_age;
    assign o_lat   = r_lat;

endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard for an in-order pipeline: RAW stall and forward-source select.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREGS    = 16,
    parameter int DEPTH    = 4,
    parameter int NRD      = 2,
    parameter int KILL     = 1,
    parameter int ZERO_REG = 1,
    localparam int RW      = rw_f(NREGS),
    localparam int LW      = lw_f(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [RW-1:0]     issue_rd,
    input  logic [LW-1:0]     issue_lat,
    input  logic [NRD*RW-1:0] issue_rs,
    input  logic [NRD-1:0]    issue_rs_used,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic [NRD*LW-1:0] fwd_sel,
    output logic [NREGS-1:0]  pending,
    output logic              accept
);

    localparam bit ZR = (ZERO_REG != 32'sd0);

    logic [NREGS-1:0]  w_valid;
    logic [NREGS-1:0]  w_load;
    logic [LW-1:0]     w_age [NREGS];
    logic [LW-1:0]     w_lat [NREGS];
    logic [NRD-1:0]    w_port_stall;
    logic [NRD*LW-1:0] w_fwd;
    logic              w_stall;
    logic              w_accept;

    assign w_stall  = rst_n & issue_valid & (|w_port_stall);
    assign w_accept = rst_n & issue_valid & ~w_stall & ~hold & ~flush;

    // Destination decode: only an accepted writing instruction loads an entry.
    always_comb begin
        w_load = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            if ((issue_rd == RW'(r)) && !(ZR && (r == 0))) begin
                w_load[r] = w_accept & issue_we;
            end else begin
                w_load[r] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_entry
        sb_entry #(
            .DEPTH (DEPTH),
            .KILL  (KILL),
            .LW    (LW)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_lat   (issue_lat),
            .i_adv   (~hold),
            .i_flush (flush),
            .o_valid (w_valid[g]),
            .o_age   (w_age[g]),
            .o_lat   (w_lat[g])
        );
    end

    // Per read port: forward once the producer reached its latency, else stall.
    always_comb begin
        w_port_stall = {NRD{1'b0}};
        w_fwd        = {(NRD*LW){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (issue_rs_used[k] && w_valid[issue_rs[k*RW +: RW]] &&
                !(ZR && (issue_rs[k*RW +: RW] == {RW{1'b0}}))) begin
                if (w_age[issue_rs[k*RW +: RW]] >= w_lat[issue_rs[k*RW +: RW]]) begin
                    w_fwd[k*LW +: LW] = w_age[issue_rs[k*RW +: RW]];
                end else begin
                    w_port_stall[k] = 1'b1;
                end
            end else begin
                w_fwd[k*LW +: LW] = LW'(FWD_REGFILE);
            end
        end
    end

    assign stall   = w_stall;
    assign accept  = w_accept;
    assign fwd_sel = rst_n ? w_fwd : {(NRD*LW){1'b0}};
    assign pending = w_valid & {NREGS{rst_n}};

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard (DEPTH=4, NREGS=16, NRD=2, KILL=1).
module tb_pipe_scoreboard;
    import pipe_pkg::*;

    localparam int NREGS = 16;
    localparam int DEPTH = 4;
    localparam int NRD   = 2;
    localparam int KILL  = 1;
    localparam int RW    = 4;
    localparam int LW    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_we;
    logic [RW-1:0]     issue_rd;
    logic [LW-1:0]     issue_lat;
    logic [NRD*RW-1:0] issue_rs;
    logic [NRD-1:0]    issue_rs_used;
    logic              hold;
    logic              flush;
    logic              stall;
    logic [NRD*LW-1:0] fwd_sel;
    logic [NREGS-1:0]  pending;
    logic              accept;

    always #5 clk = ~clk;

    pipe_scoreboard #(
        .NREGS(NREGS), .DEPTH(DEPTH), .NRD(NRD), .KILL(KILL), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .issue_rs(issue_rs),
        .issue_rs_used(issue_rs_used), .hold(hold), .flush(flush),
        .stall(stall), .fwd_sel(fwd_sel), .pending(pending), .accept(accept)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit armed  = 1'b0;

    // Pipeline model: stage s holds the instruction issued s edges ago.
    bit m_v   [1:DEPTH];
    int m_rd  [1:DEPTH];
    int m_lat [1:DEPTH];

    logic              e_stall;
    logic              e_acc;
    logic [NRD*LW-1:0] e_fwd;
    logic [NREGS-1:0]  e_pend;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Stage number of the newest in-flight producer of r, 0 when none.
    function automatic int age_of(input int r);
        for (int s = 1; s <= DEPTH; s++) begin
            if (m_v[s] && (m_rd[s] == r)) return s;
        end
        return 0;
    endfunction

    function automatic void expect_now(output logic st, output logic [NRD*LW-1:0] fw,
                                       output logic [NREGS-1:0] pe);
        int rs;
        int a;
        st = 1'b0;
        fw = '0;
        pe = '0;
        if (rst_n) begin
            for (int r = 1; r < NREGS; r++) pe[r] = (age_of(r) != 0);
            for (int k = 0; k < NRD; k++) begin
                rs = int'(issue_rs[k*RW +: RW]);
                a  = age_of(rs);
                if (issue_rs_used[k] && (rs != 0) && (a != 0)) begin
                    if (a >= m_lat[a]) fw[k*LW +: LW] = a[LW-1:0];
                    else st = st | issue_valid;
                end
            end
        end
    endfunction

    task automatic model_edge();
        logic              st;
        logic [NRD*LW-1:0] fw;
        logic [NREGS-1:0]  pe;
        bit                ld;
        expect_now(st, fw, pe);
        if (!rst_n) begin
            for (int s = 1; s <= DEPTH; s++) m_v[s] = 1'b0;
        end else if (flush) begin
            for (int s = DEPTH; s >= 2; s--) begin
                m_v[s]   = m_v[s-1] && ((s - 1) > KILL);
                m_rd[s]  = m_rd[s-1];
                m_lat[s] = m_lat[s-1];
            end
            m_v[1] = 1'b0;
        end else if (!hold) begin
            for (int s = DEPTH; s >= 2; s--) begin
                m_v[s]   = m_v[s-1];
                m_rd[s]  = m_rd[s-1];
                m_lat[s] = m_lat[s-1];
            end
            ld = issue_valid && !st && issue_we && (issue_rd != 0);
            if (ld) begin
                for (int s = 2; s <= DEPTH; s++) if (m_rd[s] == int'(issue_rd)) m_v[s] = 1'b0;
            end
            m_v[1]   = ld;
            m_rd[1]  = int'(issue_rd);
            m_lat[1] = int'(issue_lat);
        end
    endtask

    // Every cycle: DUT outputs against the model and the present inputs.
    always @(negedge clk) begin
        if (armed) begin
            expect_now(e_stall, e_fwd, e_pend);
            e_acc = rst_n & issue_valid & ~e_stall & ~hold & ~flush;
            chk("stall", stall, e_stall);
            chk("accept", accept, e_acc);
            chk("fwd_sel", fwd_sel, e_fwd);
            chk("pending", pending, e_pend);
        end
    end

    task automatic drive(input int v, input int we, input int rd, input int lat,
                         input int rs0, input int u0, input int rs1, input int u1);
        issue_valid   = v[0];
        issue_we      = we[0];
        issue_rd      = rd[RW-1:0];
        issue_lat     = lat[LW-1:0];
        issue_rs      = {rs1[RW-1:0], rs0[RW-1:0]};
        issue_rs_used = {u1[0], u0[0]};
        hold          = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 1) step();
    endtask

    function automatic int fwd(input int k);
        return int'(fwd_sel[k*LW +: LW]);
    endfunction

    initial begin
        int exp_fwd  [5];
        int exp_pend [5];
        for (int s = 1; s <= DEPTH; s++) begin
            m_v[s] = 1'b0; m_rd[s] = 0; m_lat[s] = 0;
        end
        rst_n = 1'b0;
        drive(1, 1, 3, 1, 3, 1, 0, 0);
        step();
        armed = 1'b1;
        @(negedge clk);
        chk("reset_pending", pending, 0);
        chk("reset_stall", stall, 0);
        chk("reset_fwd", fwd_sel, 0);
        chk("reset_accept", accept, 0);
        step();
        rst_n = 1'b1;
        drain();

        // RAW forwarding: lat=1 producer of r3, consumer follows each cycle
        exp_fwd = '{1, 2, 3, 4, 0};
        drive(1, 1, 3, 1, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 3, 1, 0, 0);
            @(negedge clk);
            chk("raw_stall", stall, 0);
            chk("raw_fwd", fwd(0), exp_fwd[i]);
            step();
        end
        drain();

        // Load-use on read port 1
        drive(1, 1, 5, 2, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 5, 1);
        @(negedge clk);
        chk("lu_stall", stall, 1);
        chk("lu_accept", accept, 0);
        step();
        @(negedge clk);
        chk("lu_stall2", stall, 0);
        chk("lu_fwd", fwd(1), 2);
        step();
        drain();

        // WAW: newer lat=1 producer of r2 replaces the lat=2 one
        drive(1, 1, 2, 2, 0, 0, 0, 0);
        step();
        drive(1, 1, 2, 1, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 2, 1, 0, 0);
        @(negedge clk);
        chk("waw_fwd", fwd(0), 1);
        chk("waw_stall", stall, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_pend = '{1, 1, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("waw_pending", pending[2], exp_pend[i]);
            step();
        end
        drain();

        // Flush: r7 (age 1) dies, r9 (age 2) survives, r11 is not accepted
        drive(1, 1, 9, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 7, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 11, 1, 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_accept", accept, 0);
        step();
        drive(1, 0, 0, 0, 7, 1, 9, 1);
        @(negedge clk);
        chk("fl_pend7", pending[7], 0);
        chk("fl_pend9", pending[9], 1);
        chk("fl_pend11", pending[11], 0);
        chk("fl_fwd7", fwd(0), 0);
        chk("fl_fwd9", fwd(1), 3);
        step();
        drain();

        // Hold freezes ages for two cycles; r4 reaches writeback two cycles late
        drive(1, 1, 4, 1, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 6, 1, 4, 1, 0, 0);
            hold = 1'b1;
            @(negedge clk);
            chk("hold_fwd", fwd(0), 1);
            chk("hold_accept", accept, 0);
            step();
        end
        exp_fwd  = '{1, 2, 3, 4, 0};
        exp_pend = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 4, 1, 0, 0);
            @(negedge clk);
            if (i == 0) chk("hold_pend6", pending[6], 0);
            chk("hold_fwd_run", fwd(0), exp_fwd[i]);
            chk("hold_pend4", pending[4], exp_pend[i]);
            step();
        end
        drain();

        // r0 never tracked; reset mid-operation clears three live entries
        drive(1, 1, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("r0_fwd", fwd(0), 0);
        step();
        drive(1, 1, 1, 3, 0, 1, 0, 0);
        @(negedge clk);
        chk("r0_pend", pending[0], 0);
        step();
        drive(1, 1, 8, 2, 0, 0, 0, 0);
        step();
        drive(1, 1, 12, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 13, 1, 1, 1, 8, 1);
        @(negedge clk);
        chk("rs_pend_live", pending, 16'h1102);
        chk("rs_fwd1", fwd(0), 3);
        chk("rs_fwd8", fwd(1), 2);
        step();
        rst_n = 1'b0;
        hold  = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("rs_pend_low", pending, 0);
        chk("rs_fwd_low", fwd_sel, 0);
        chk("rs_accept_low", accept, 0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 8, 1, 12, 1);
        @(negedge clk);
        chk("rs_pend_after", pending, 0);
        chk("rs_fwd_after", fwd_sel, 0);
        step();

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, $urandom % 2, $urandom % 16, 1 + ($urandom % 4),
                  $urandom % 16, $urandom % 2, $urandom % 16, $urandom % 2);
            hold  = (($urandom % 8) == 0);
            flush = (($urandom % 10) == 0);
            rst_n = (($urandom % 60) != 0);
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
